vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator; next generation of the fixed 640x480 sync generator. Produces pixel clock-enable, sync, data-enable, pixel coordinates and line/frame strobes for any mode set by parameters. Runs entirely in the `clk` domain, with no derived clocks. Feeds the pixel pipeline and the DAC/pin stage.

---
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel strobe, syncs, DE, coordinates, line/frame strobes.
// Latency: outputs are registered on each pix_ce edge from the pre-increment h/v, one pixel behind.
// Backpressure: none; en=0 freezes all state. VGA_TIMING_FRAME_CNT_EN adds the frame_cnt output.
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int CW       = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   output logic          pix_ce,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]   frame_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   // Sync windows are half-open: [START, END).
   localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          HS_ON    = (HS_POL != 0);
   localparam logic          VS_ON    = (VS_POL != 0);

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
      $error("vga_timing_gen: timing parameters must be non-zero");
   end
   if ((longint'(1) << CW) < longint'(H_TOTAL) ||
       (longint'(1) << CW) < longint'(V_TOTAL)) begin : g_bad_cw
      $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
   end

   logic [DW-1:0] div_cnt;
   logic [CW-1:0] h;
   logic [CW-1:0] v;

   // Combinational so that CLK_DIV=1 gives pix_ce=en; forced low while in reset.
   assign pix_ce = en && !reset && (div_cnt == DIV_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h <= '0;
         v <= '0;
      end else if (pix_ce) begin
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end
   end

   // Strobes drop on the next clk edge, so they stay one clk wide for any CLK_DIV.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x           <= '0;
         y           <= '0;
         de          <= 1'b0;
         hsync       <= ~HS_ON;
         vsync       <= ~VS_ON;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (pix_ce) begin
            x           <= h;
            y           <= v;
            de          <= (h < H_ACT) && (v < V_ACT);
            hsync       <= (h >= HS_START && h < HS_END) ? HS_ON : ~HS_ON;
            vsync       <= (v >= VS_START && v < VS_END) ? VS_ON : ~VS_ON;
            line_start  <= (h == '0);
            frame_start <= (h == '0) && (v == '0);
         end
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (pix_ce && h == '0 && v == '0) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a tiny 8x6 mode, CLK_DIV=3, mixed sync polarity.
// Outputs are compared every clk against a pixel-index model derived from the count of enabled cycles.
module tb_vga_timing_gen;

   localparam int CD = 3;
   localparam int HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int CW = 4;
   localparam logic HS_ON = 1'b0;
   localparam logic VS_ON = 1'b1;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic          pix_ce, hsync, vsync, de, line_start, frame_start;
   logic [CW-1:0] x, y;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0]   frame_cnt;
`endif

   vga_timing_gen #(
      .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(0), .VS_POL(1), .CW(CW)
   ) u_dut (
      .clk(clk), .reset(reset), .en(en), .pix_ce(pix_ce),
      .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
      .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          e_cnt = 0;
   logic        ce_exp = 1'b0;
   logic [15:0] fc_model = 16'd0;
   int          ex = 0, ey = 0;
   bit          measure = 0;
   int          m_cyc, m_de, m_hs, m_vs, m_ls;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: pixel k = (enabled cycles / CD) - 1 is on the outputs; raster position follows from k.
   task automatic check_outputs();
      int   n, k;
      logic ede, ehs, evs, els, efs;
      n = e_cnt / CD;
      if (n == 0) begin
         ex = 0; ey = 0; ede = 1'b0; ehs = ~HS_ON; evs = ~VS_ON;
      end else begin
         k   = n - 1;
         ex  = k % HT;
         ey  = (k / HT) % VT;
         ede = (ex < HA) && (ey < VA);
         ehs = (ex >= HA + HF && ex < HA + HF + HS) ? HS_ON : ~HS_ON;
         evs = (ey >= VA + VF && ey < VA + VF + VS) ? VS_ON : ~VS_ON;
      end
      els = ce_exp && (ex == 0);
      efs = els && (ey == 0);
      if (efs) fc_model = fc_model + 16'd1;
      chk("x", 32'(x), 32'(ex));
      chk("y", 32'(y), 32'(ey));
      chk("de", 32'(de), 32'(ede));
      chk("hsync", 32'(hsync), 32'(ehs));
      chk("vsync", 32'(vsync), 32'(evs));
      chk("line_start", 32'(line_start), 32'(els));
      chk("frame_start", 32'(frame_start), 32'(efs));
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("frame_cnt", 32'(frame_cnt), 32'(fc_model));
`endif
   endtask

   task automatic step(input logic en_v);
      @(negedge clk);
      reset = 1'b0;
      en    = en_v;
      #1;
      ce_exp = en_v && (e_cnt % CD == CD - 1);
      chk("pix_ce", 32'(pix_ce), 32'(ce_exp));
      @(posedge clk);
      #1;
      if (en_v) e_cnt++;
      check_outputs();
      if (measure) begin
         m_cyc++;
         m_de += int'(de);
         m_hs += int'(hsync == HS_ON);
         m_vs += int'(vsync == VS_ON);
         m_ls += int'(line_start);
      end
   endtask

   // Reset is asserted mid-cycle; outputs must clear at once, not at the next clk edge.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      e_cnt    = 0;
      ce_exp   = 1'b0;
      fc_model = 16'd0;
      chk("pix_ce_rst", 32'(pix_ce), 32'd0);
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic expect_first_frame(input string tag);
      int cnt  = 0;
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1'b1);
         cnt++;
         seen = (frame_start === 1'b1);
      end
      chk(tag, 32'(cnt), 32'(CD));
   endtask

   task automatic run_to(input int tx, input int ty, input string tag);
      bit hit = 0;
      for (int i = 0; i < 4 * FT * CD && !hit; i++) begin
         step(1'b1);
         hit = (ce_exp && ex == tx && ey == ty);
      end
      chk(tag, 32'(hit), 32'd1);
   endtask

   initial begin
      int cnt;
      int div_phase;
      bit seen;

      reset = 1'b0;
      en    = 1'b0;
      #2 reset = 1'b1;

      // Reset state and first pixel timing.
      do_reset();
      expect_first_frame("first_frame_latency");

      // One full frame measured between consecutive frame_start pulses.
      measure = 0;
      m_cyc = 0; m_de = 0; m_hs = 0; m_vs = 0; m_ls = 0;
      measure = 1;
      seen = 0;
      for (int i = 0; i < 2 * FT * CD && !seen; i++) begin
         step(1'b1);
         seen = (frame_start === 1'b1);
      end
      measure = 0;
      chk("frame_period", 32'(m_cyc), 32'(FT * CD));
      chk("de_clks_per_frame", 32'(m_de), 32'(HA * VA * CD));
      chk("hsync_clks_per_frame", 32'(m_hs), 32'(HS * CD * VT));
      chk("vsync_clks_per_frame", 32'(m_vs), 32'(VS * HT * CD));
      chk("lines_per_frame", 32'(m_ls), 32'(VT));

      // Freeze at x=3 for 7 clk, mid-pixel, then resume.
      run_to(3, 1, "reach_x3");
      step(1'b1);
      div_phase = e_cnt % CD;
      for (int i = 0; i < 7; i++) step(1'b0);
      chk("frozen_x", 32'(x), 32'd3);
      cnt  = 0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1'b1);
         cnt++;
         seen = (x == 4'd4);
      end
      chk("resume_latency", 32'(cnt), 32'(CD - div_phase));

      // Mid-frame reset at y=2, x=6.
      run_to(6, 2, "reach_y2x6");
      do_reset();
      expect_first_frame("restart_latency");

`ifdef VGA_TIMING_FRAME_CNT_EN
      for (int f = 0; f < 2; f++) run_to(0, 0, "frame_cnt_frame");
      chk("frame_cnt_after_3", 32'(frame_cnt), 32'd3);
      run_to(2, 3, "reach_force_point");
      @(negedge clk);
      force u_dut.frame_cnt = 16'hFFFF;
      #1 release u_dut.frame_cnt;
      fc_model = 16'hFFFF;
      run_to(0, 0, "frame_cnt_wrap_frame");
      chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
`endif

      // Random enable gaps with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         else step(logic'($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
